// File: rtl/window_streamer_if.sv
// Stream bundle for window_streamer: a raster pixel stream in, 3-pixel
// horizontal windows out, plus the row/frame markers that travel with them.
interface window_streamer_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0]        in_pixel;
  logic                          in_valid;
  logic                          in_ready;
  // Index 0 is the oldest pixel and sits in the most significant slot, so the
  // packed value reads {oldest, middle, newest}.
  logic [0:2][PIXEL_WIDTH-1:0]   out_window;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_row_end;
  logic                          frame_done;

  // Streamer side.
  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_row_end, frame_done
  );

  // Source / sink side.
  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_row_end, frame_done
  );
endinterface

// File: rtl/window_streamer.sv
// window_streamer: turns a row-major pixel stream into 3-wide horizontal
// windows. A window is only formed once two pixels of the current row are in
// the history, so windows never span two rows. One output register slot;
// upstream is stalled only while that slot is full and not being drained.
module window_streamer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ROW_LEN     = 8,
  parameter int NUM_ROWS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  window_streamer_if.slave io_bus
);

  localparam int CW = $clog2(ROW_LEN);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);

  logic [CW-1:0]               r_col;
  logic [RW-1:0]               r_row;
  logic [PIXEL_WIDTH-1:0]      r_h0;
  logic [PIXEL_WIDTH-1:0]      r_h1;
  logic [0:2][PIXEL_WIDTH-1:0] r_window;
  logic                        r_out_valid;
  logic                        r_row_end;
  logic                        r_frame_done;

  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_col_last;
  logic w_row_last;
  logic w_win_load;

  // Handshake decode; ready depends only on the output slot, never on in_valid.
  always_comb begin
    w_in_ready = !r_out_valid || io_bus.out_ready;
    w_in_xfer  = io_bus.in_valid && w_in_ready;
    w_out_xfer = r_out_valid && io_bus.out_ready;
    w_col_last = (r_col == COL_LAST);
    w_row_last = (r_row == ROW_LAST);
    w_win_load = w_in_xfer && (r_col >= COL_FIRST_WIN);
  end

  // Pixel history and raster position, advanced once per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_h0  <= '0;
      r_h1  <= '0;
    end else if (w_in_xfer) begin
      r_h0 <= r_h1;
      r_h1 <= io_bus.in_pixel;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Output slot: reload on a window-forming pixel (even while draining the
  // previous window, for one window per cycle), otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window    <= '0;
      r_row_end   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_win_load) begin
      r_window    <= {r_h0, r_h1, io_bus.in_pixel};
      r_row_end   <= w_col_last;
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // One-cycle pulse after the final pixel of a frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_in_xfer && w_col_last && w_row_last;
    end
  end

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.out_window  = r_window;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_row_end = r_row_end;
  assign io_bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_window_streamer.sv
// Bench for window_streamer (ROW_LEN=8, NUM_ROWS=2). A reference model fed
// from accepted pixels pushes expected windows into a queue; the monitor
// compares the held window against the queue head each cycle and pops on
// every output transfer. Directed steps also check specific windows.
module tb_window_streamer;
  localparam int PW = 8;
  localparam int RL = 8;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;

  window_streamer_if #(.PIXEL_WIDTH(PW)) bus ();

  window_streamer #(
    .PIXEL_WIDTH(PW),
    .ROW_LEN(RL),
    .NUM_ROWS(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];
  int          m_col = 0;
  int          m_row = 0;
  logic [7:0]  m_h0 = '0;
  logic [7:0]  m_h1 = '0;
  logic        fd_next = 1'b0;
  int          fd_count = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'((exp_q.size() == 0) || bus.out_ready));
      chk("frame_done", 32'(bus.frame_done), 32'(fd_next));
      if (bus.frame_done === 1'b1) fd_count++;
      if (bus.out_valid === 1'b1 && exp_q.size() != 0)
        chk("window", 32'({bus.out_window, bus.out_row_end}), 32'(exp_q[0]));
      if (rst) begin
        exp_q.delete();
        m_col = 0; m_row = 0; m_h0 = '0; m_h1 = '0;
        fd_next = 1'b0;
      end else begin
        fd_next = bus.in_valid && bus.in_ready && (m_row == NR-1) && (m_col == RL-1);
        if (bus.out_valid === 1'b1 && bus.out_ready) begin
          got_q.push_back({bus.out_window, bus.out_row_end});
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          if (m_col >= 2) exp_q.push_back({m_h0, m_h1, bus.in_pixel, m_col == RL-1});
          m_h0 = m_h1;
          m_h1 = bus.in_pixel;
          if (m_col == RL-1) begin
            m_col = 0;
            m_row = (m_row == NR-1) ? 0 : m_row + 1;
          end else begin
            m_col = m_col + 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input bit rnd);
    int n = 0;
    bit acc = 1'b0;
    if (rnd) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    bus.in_pixel = p;
    bus.in_valid = 1'b1;
    do begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset values while rst is still asserted.
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_window", 32'(bus.out_window), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Two full rows back-to-back, then the first pixel of the next frame.
    for (int p = 1; p <= 16; p++) send(8'(p), 1'b0);
    idle(3);
    chk("row_win_count", 32'(got_q.size()), 32'd12);
    chk("row0_first", 32'(got_q[0]), 32'({8'd1, 8'd2, 8'd3, 1'b0}));
    chk("row0_last", 32'(got_q[5]), 32'({8'd6, 8'd7, 8'd8, 1'b1}));
    chk("row1_first", 32'(got_q[6]), 32'({8'd9, 8'd10, 8'd11, 1'b0}));
    chk("row1_last", 32'(got_q[11]), 32'({8'd14, 8'd15, 8'd16, 1'b1}));
    chk("frame_done_once", 32'(fd_count), 32'd1);
    send(8'd17, 1'b0);
    idle(2);
    chk("new_frame_no_win", 32'(got_q.size()), 32'd12);
    chk("new_frame_idle", 32'(bus.out_valid), 32'd0);

    // Backpressure on window (2,3,4) for five cycles.
    do_reset();
    got_q.delete();
    for (int p = 1; p <= 4; p++) send(8'(p), 1'b0);
    bus.out_ready = 1'b0;
    bus.in_pixel  = 8'd5;
    bus.in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_window", 32'(bus.out_window), 32'({8'd2, 8'd3, 8'd4}));
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int p = 5; p <= 8; p++) send(8'(p), 1'b0);
    idle(3);
    chk("bp_count", 32'(got_q.size()), 32'd6);
    chk("bp_held", 32'(got_q[1]), 32'({8'd2, 8'd3, 8'd4, 1'b0}));
    chk("bp_next", 32'(got_q[2]), 32'({8'd3, 8'd4, 8'd5, 1'b0}));

    // Random handshakes over three frames.
    do_reset();
    got_q.delete();
    fd_count = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < RL*NR; i++) send(8'($urandom_range(0, 255)), 1'b1);
    bus.out_ready = 1'b1;
    idle(4);
    chk("rnd_win_count", 32'(got_q.size()), 32'd36);
    chk("rnd_frames", 32'(fd_count), 32'd3);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a row.
    do_reset();
    bus.out_ready = 1'b1;
    for (int p = 1; p <= 5; p++) send(8'(p), 1'b0);
    do_reset();
    got_q.delete();
    send(8'd20, 1'b0);
    send(8'd21, 1'b0);
    send(8'd22, 1'b0);
    idle(3);
    chk("mid_rst_count", 32'(got_q.size()), 32'd1);
    chk("mid_rst_first", 32'(got_q[0]), 32'({8'd20, 8'd21, 8'd22, 1'b0}));

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
